// File: rtl/tt_pkg.sv
// Shared constants and FSM state type for the truth-table sweep engine.
package tt_pkg;

    localparam int N_IN      = 7;
    localparam int N_MINTERM = 128;
    localparam int IDX_W     = 7;
    localparam int CNT_W     = 8;

    // Sweep controller states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } tt_state_t;

endpackage : tt_pkg

// File: rtl/tt_lat_pipe.sv
// Delay line for {valid, minterm index} tags. It matches the latency of the
// function block, so each f_in sample lines up with the minterm that produced
// it. At depth 0 it is a plain wire.
module tt_lat_pipe
    import tt_pkg::*;
#(
    parameter int DEPTH = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid_i,
    input  logic [IDX_W-1:0] in_idx_i,
    output logic             out_valid_o,
    output logic [IDX_W-1:0] out_idx_o
);

    generate
        if (DEPTH == 0) begin : g_wire
            assign out_valid_o = in_valid_i;
            assign out_idx_o   = in_idx_i;
        end else begin : g_pipe
            // Each stage holds {valid, index}. Stage 0 is the newest entry.
            logic [DEPTH-1:0][IDX_W:0] stage_q;

            // Shift register; reset clears every valid bit so no stale tag
            // can emerge after an aborted sweep.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    stage_q <= '0;
                end else begin
                    stage_q[0] <= {in_valid_i, in_idx_i};
                    for (int k = 1; k < DEPTH; k++) begin
                        stage_q[k] <= stage_q[k-1];
                    end
                end
            end

            assign out_valid_o = stage_q[DEPTH-1][IDX_W];
            assign out_idx_o   = stage_q[DEPTH-1][IDX_W-1:0];
        end
    endgenerate

endmodule : tt_lat_pipe

// File: rtl/tt_sweep_capture.sv
// Truth-table sweep engine. It walks x through all 128 minterms of a 7-input
// function block and captures f_in into a truth table. The table is compared
// bit by bit against EXP_TT, and the engine reports the error count and the
// lowest failing minterm.
module tt_sweep_capture
    import tt_pkg::*;
#(
    parameter logic [N_MINTERM-1:0] EXP_TT  = 128'hfeeafce8fee8e880fee8e880e8c0a880,
    parameter int                   DUT_LAT = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    output logic [N_IN-1:0]      x,
    input  logic                 f_in,
    output logic                 busy,
    output logic                 done,
    output logic [N_MINTERM-1:0] tt,
    output logic                 match,
    output logic [CNT_W-1:0]     err_cnt,
    output logic [IDX_W-1:0]     first_err,
    output logic                 err_valid
);

    // Last DRAIN count value; DRAIN is unreachable when DUT_LAT is 0.
    localparam logic [1:0] DRAIN_LAST = (DUT_LAT > 0) ? 2'(DUT_LAT - 1) : 2'd0;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_MINTERM - 1);

    tt_state_t              state_q, state_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [1:0]             drain_q, drain_d;
    logic [N_MINTERM-1:0]   tt_q, tt_d;
    logic [CNT_W-1:0]       err_cnt_q, err_cnt_d;
    logic [IDX_W-1:0]       first_err_q, first_err_d;
    logic                   err_valid_q, err_valid_d;
    logic                   match_q, match_d;

    logic                   issue_valid;
    logic                   cap_valid;
    logic [IDX_W-1:0]       cap_idx;
    logic                   cap_mismatch;

    // A minterm is issued on every DRIVE cycle.
    assign issue_valid = (state_q == ST_DRIVE);

    generate
        if (DUT_LAT == 0) begin : g_no_pipe
            assign cap_valid = issue_valid;
            assign cap_idx   = idx_q;
        end else begin : g_pipe
            tt_lat_pipe #(
                .DEPTH(DUT_LAT)
            ) u_lat_pipe (
                .clk        (clk),
                .rst        (rst),
                .in_valid_i (issue_valid),
                .in_idx_i   (idx_q),
                .out_valid_o(cap_valid),
                .out_idx_o  (cap_idx)
            );
        end
    endgenerate

    assign cap_mismatch = cap_valid && (f_in != EXP_TT[cap_idx]);

    // Next-state logic for the sweep FSM, plus capture and result accumulation.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        drain_d     = drain_q;
        tt_d        = tt_q;
        err_cnt_d   = err_cnt_q;
        first_err_d = first_err_q;
        err_valid_d = err_valid_q;
        match_d     = match_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d     = ST_DRIVE;
                    idx_d       = '0;
                    tt_d        = '0;
                    err_cnt_d   = '0;
                    first_err_d = '0;
                    err_valid_d = 1'b0;
                    match_d     = 1'b0;
                end
            end
            ST_DRIVE: begin
                idx_d = idx_q + 1'b1;
                if (idx_q == IDX_LAST) begin
                    drain_d = 2'd0;
                    state_d = (DUT_LAT > 0) ? ST_DRAIN : ST_DONE;
                end
            end
            ST_DRAIN: begin
                drain_d = drain_q + 1'b1;
                if (drain_q == DRAIN_LAST) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Capture: tags only emerge during DRIVE/DRAIN, so this never
        // collides with the clear on start.
        if (cap_valid) begin
            tt_d[cap_idx] = f_in;
        end
        if (cap_mismatch) begin
            err_cnt_d = err_cnt_q + 1'b1;
            if (!err_valid_q) begin
                first_err_d = cap_idx;
                err_valid_d = 1'b1;
            end
        end

        // The verdict uses the count after the final capture, so match is
        // already valid in the DONE cycle.
        if (state_d == ST_DONE) begin
            match_d = (err_cnt_d == '0);
        end
    end

    // State and result registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            drain_q     <= 2'd0;
            tt_q        <= '0;
            err_cnt_q   <= '0;
            first_err_q <= '0;
            err_valid_q <= 1'b0;
            match_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            drain_q     <= drain_d;
            tt_q        <= tt_d;
            err_cnt_q   <= err_cnt_d;
            first_err_q <= first_err_d;
            err_valid_q <= err_valid_d;
            match_q     <= match_d;
        end
    end

    // Minterm drive: the counter during DRIVE, held at 127 while draining,
    // and 0 otherwise.
    always_comb begin
        x = '0;
        if (state_q == ST_DRIVE) begin
            x = idx_q;
        end else if (state_q == ST_DRAIN) begin
            x = IDX_LAST;
        end
    end

    assign busy      = (state_q == ST_DRIVE) || (state_q == ST_DRAIN);
    assign done      = (state_q == ST_DONE);
    assign tt        = tt_q;
    assign match     = match_q;
    assign err_cnt   = err_cnt_q;
    assign first_err = first_err_q;
    assign err_valid = err_valid_q;

endmodule : tt_sweep_capture

// File: tb/tb_tt_sweep_capture.sv
// Scoreboard bench for tt_sweep_capture. Two instances are exercised in
// lockstep: one with zero latency and one with a two-stage registered block.
module tb_tt_sweep_capture;

    localparam logic [127:0] EXP = 128'hfeeafce8fee8e880fee8e880e8c0a880;

    typedef struct {
        logic [127:0] tt;
        logic         match;
        logic [7:0]   cnt;
        logic [6:0]   fe;
        logic         ev;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;

    // Truth table of the function block currently attached (possibly faulty).
    logic [127:0] ft = EXP;

    logic [6:0]   x0, x2;
    logic         f0, f2, p1, p2;
    logic         busy0, busy2, done0, done2;
    logic [127:0] tt0, tt2;
    logic         match0, match2, ev0, ev2;
    logic [7:0]   cnt0, cnt2;
    logic [6:0]   fe0, fe2;

    int n_checks = 0;
    int n_fail   = 0;

    exp_t q0[$];
    exp_t q2[$];
    int   bc0 = 0;
    int   bc2 = 0;

    always #5 clk = ~clk;

    // Function block models: combinational, and registered twice.
    assign f0 = ft[x0];
    always @(posedge clk) begin
        p1 <= ft[x2];
        p2 <= p1;
    end
    assign f2 = p2;

    tt_sweep_capture #(.EXP_TT(EXP), .DUT_LAT(0)) dut0 (
        .clk(clk), .rst(rst), .start(start), .x(x0), .f_in(f0),
        .busy(busy0), .done(done0), .tt(tt0), .match(match0),
        .err_cnt(cnt0), .first_err(fe0), .err_valid(ev0)
    );

    tt_sweep_capture #(.EXP_TT(EXP), .DUT_LAT(2)) dut2 (
        .clk(clk), .rst(rst), .start(start), .x(x2), .f_in(f2),
        .busy(busy2), .done(done2), .tt(tt2), .match(match2),
        .err_cnt(cnt2), .first_err(fe2), .err_valid(ev2)
    );

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual %h required %h", name, act, req);
        end
    endtask

    // Reference: the captured table is the attached function itself; errors
    // are the positions where it disagrees with the expected signature.
    function automatic exp_t model(input logic [127:0] f);
        exp_t e;
        int   c;
        int   first;
        c = 0;
        first = -1;
        for (int m = 0; m < 128; m++) begin
            if (f[m] != EXP[m]) begin
                c++;
                if (first < 0) first = m;
            end
        end
        e.tt    = f;
        e.cnt   = c[7:0];
        e.ev    = (c != 0);
        e.match = (c == 0);
        e.fe    = (first < 0) ? 7'd0 : first[6:0];
        return e;
    endfunction

    task automatic check_result(input string tag, input exp_t e, input logic [127:0] att,
                                input logic am, input logic [7:0] ac, input logic [6:0] afe,
                                input logic aev, input int bcnt, input int lat, input logic ab);
        $display("%s result: err_cnt=%0d first_err=%0d match=%0b busy_cycles=%0d",
                 tag, ac, afe, am, bcnt);
        chk({tag, ".tt"}, att, e.tt);
        chk({tag, ".match"}, 128'(am), 128'(e.match));
        chk({tag, ".err_cnt"}, 128'(ac), 128'(e.cnt));
        chk({tag, ".first_err"}, 128'(afe), 128'(e.fe));
        chk({tag, ".err_valid"}, 128'(aev), 128'(e.ev));
        chk({tag, ".busy_cycles"}, 128'(bcnt), 128'(128 + lat));
        chk({tag, ".busy_in_done"}, 128'(ab), 128'(0));
    endtask

    // Monitor for the zero-latency instance.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            bc0 = 0;
        end else begin
            if (busy0) begin
                chk("lat0.x", 128'(x0), 128'((bc0 < 128) ? bc0 : 127));
                bc0++;
            end
            if (done0) begin
                if (q0.size() == 0) begin
                    chk("lat0.unexpected_done", 128'(1), 128'(0));
                end else begin
                    e = q0.pop_front();
                    check_result("lat0", e, tt0, match0, cnt0, fe0, ev0, bc0, 0, busy0);
                end
                bc0 = 0;
            end
        end
    end

    // Monitor for the two-cycle-latency instance.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            bc2 = 0;
        end else begin
            if (busy2) begin
                chk("lat2.x", 128'(x2), 128'((bc2 < 128) ? bc2 : 127));
                bc2++;
            end
            if (done2) begin
                if (q2.size() == 0) begin
                    chk("lat2.unexpected_done", 128'(1), 128'(0));
                end else begin
                    e = q2.pop_front();
                    check_result("lat2", e, tt2, match2, cnt2, fe2, ev2, bc2, 2, busy2);
                end
                bc2 = 0;
            end
        end
    end

    task automatic wait_drain();
        int c;
        c = 0;
        while ((q0.size() != 0 || q2.size() != 0) && c < 400) begin
            @(posedge clk);
            c++;
        end
        if (q0.size() != 0 || q2.size() != 0) begin
            chk("sweep_timeout", 128'(q0.size() + q2.size()), 128'(0));
            q0.delete();
            q2.delete();
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic run_sweep(input logic [127:0] tbl, input bit mid_pulse);
        exp_t e;
        ft = tbl;
        e  = model(tbl);
        q0.push_back(e);
        q2.push_back(e);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        if (mid_pulse) begin
            repeat (60) @(posedge clk);
            #1 start = 1'b1;
            @(posedge clk);
            #1 start = 1'b0;
        end
        wait_drain();
    endtask

    logic [127:0] one;
    logic [127:0] tbl;

    initial begin
        one = 128'd1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset.x", 128'({x0, x2}), 128'(0));
        chk("reset.busy_done", 128'({busy0, busy2, done0, done2}), 128'(0));
        chk("reset.tt", tt0 | tt2, 128'(0));
        chk("reset.flags", 128'({match0, match2, ev0, ev2, cnt0, cnt2, fe0, fe2}), 128'(0));
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Correct block, with an ignored start pulse mid-sweep.
        run_sweep(EXP, 1'b1);
        // Output stuck at 0.
        run_sweep(128'd0, 1'b0);
        // Inverted block.
        run_sweep(~EXP, 1'b0);
        // Single-minterm fault at 99.
        run_sweep(EXP ^ (one << 99), 1'b0);
        // Random tables and random sparse faults.
        for (int k = 0; k < 4; k++) begin
            tbl = {$urandom, $urandom, $urandom, $urandom};
            run_sweep(tbl, 1'b0);
        end
        for (int k = 0; k < 4; k++) begin
            tbl = EXP ^ (one << $urandom_range(127, 0)) ^ (one << $urandom_range(127, 0));
            run_sweep(tbl, 1'b0);
        end
        // Minterm 127 and minterm 0 boundaries.
        run_sweep(EXP ^ (one << 127), 1'b0);
        run_sweep(EXP ^ one, 1'b0);

        // Asynchronous reset in the middle of a sweep.
        ft = EXP;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (50) @(posedge clk);
        #2;
        chk("pre_rst.x", 128'(x0), 128'(50));
        rst = 1'b1;
        #1;
        chk("mid_rst.x", 128'({x0, x2}), 128'(0));
        chk("mid_rst.busy_done", 128'({busy0, busy2, done0, done2}), 128'(0));
        chk("mid_rst.tt", tt0 | tt2, 128'(0));
        chk("mid_rst.flags", 128'({match0, match2, ev0, ev2, cnt0, cnt2, fe0, fe2}), 128'(0));
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("post_rst.idle", 128'({busy0, busy2, done0, done2}), 128'(0));
        run_sweep(EXP, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_tt_sweep_capture

// File: doc/tt_sweep_capture.md
# tt_sweep_capture

Truth-table sweep engine for the 7-input function blocks. It drives all 128 input minterms into one combinational (or shallowly pipelined) function block and captures the block's output into a 128-bit truth table. It then compares that table against an expected signature and reports match, error count and first failing minterm. It sits directly upstream and downstream of the function block: it feeds x0..x6 and consumes `out`.

## Interface
- `EXP_TT`, default 128'hfeeafce8fee8e880fee8e880e8c0a880: expected truth table; bit i is the output for minterm i.
- `DUT_LAT`, default 0: cycles from `x` to a valid `f_in`; legal range 0..3.
- `clk`  in  1: single clock; all state on its rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `start`  in  1: request a sweep; sampled only in IDLE.
- `x`  out  7: minterm driven to the function block; bit k drives xk, so x0 is the LSB of the minterm index.
- `f_in`  in  1: function block output.
- `busy`  out  1: sweep in progress.
- `done`  out  1: one-cycle pulse; results valid from this cycle on.
- `tt`  out  128: captured truth table.
- `match`  out  1: high when `tt` equals `EXP_TT`.
- `err_cnt`  out  8: number of mismatching minterms, range 0..128.
- `first_err`  out  7: lowest mismatching minterm index.
- `err_valid`  out  1: high when `err_cnt` is nonzero.

## Operation
- FSM states: IDLE, DRIVE, DRAIN, DONE.
- IDLE
  - `x` = 0.
  - `start` = 1 moves to DRIVE and clears `tt`, `err_cnt`, `first_err`, `err_valid` and `match`.
- DRIVE
  - 7-bit index counter i runs 0..127, one minterm per cycle; `x` = i.
  - After i = 127 is issued: go to DRAIN if `DUT_LAT` > 0, otherwise go to DONE.
- DRAIN
  - Holds `x` = 127 for `DUT_LAT` cycles, then goes to DONE.
- Capture
  - A valid/index delay line of depth `DUT_LAT` tags each issued minterm.
  - When a tag emerges with index j: `tt[j]` <= `f_in`.
  - If `f_in` differs from `EXP_TT[j]`: increment `err_cnt`. On the first such event, also set `first_err` <= j and `err_valid` <= 1.
  - With depth 0, `f_in` is sampled in the same cycle that `x` = j.
- DONE
  - Pulses `done` and sets `match` <= (`err_cnt` == 0), counting the final capture.
  - Next state is IDLE.
- Results hold until the next accepted `start`.
- `start` is ignored in DRIVE, DRAIN and DONE; no queuing.
- `err_cnt` is 8 bits wide and cannot saturate (maximum 128).
- `first_err` = 0 when `err_valid` = 0.

## Timing
- Reset: all outputs 0 (`x`, `busy`, `done`, `tt`, `match`, `err_cnt`, `first_err`, `err_valid`); FSM to IDLE; delay line cleared.
- Edge E0 is the edge that accepts `start`.
- After E0:
  - `busy` = 1 and `x` = 0.
  - In cycle n (n = 0..127), `x` = n.
- Capture of minterm n happens in cycle n + `DUT_LAT`.
- `done` is high in cycle 128 + `DUT_LAT`.
  - `busy` is low in that cycle.
  - `match` and all counts are final in that cycle.
- Sweep length: 128 + `DUT_LAT` cycles of `busy`, then one `done` cycle, then IDLE. A new `start` is accepted the cycle after `done`.
- Reset asserted mid-sweep:
  - Everything returns to its reset value immediately (asynchronous), and partial results are discarded.
  - After release, the block is in IDLE and waits for `start`.
- `start` held high continuously: a new sweep begins every 130 + `DUT_LAT` cycles, i.e. one IDLE cycle between sweeps.

## Structure
- Package `tt_pkg`:
  - `N_IN` = 7, `N_MINTERM` = 128, `IDX_W` = 7, `CNT_W` = 8.
  - FSM state enum `tt_state_t`.
- Sub-module `tt_lat_pipe`: parameterised delay line of {valid, index[6:0]} with depth `DUT_LAT`. It degenerates to a wire at depth 0 and is reset asynchronously.
- The function block under test is instantiated outside this block.

## Test plan
1. `DUT_LAT` = 0, correct majority-network block connected, single `start` -> `tt` = `EXP_TT`, `match` = 1, `err_cnt` = 0, `err_valid` = 0, `done` in cycle 128.
2. `f_in` tied to 0, default `EXP_TT` -> `err_cnt` = 64, `first_err` = 7, `match` = 0, `tt` = 0.
3. `f_in` = ~(correct output) -> `err_cnt` = 128, `first_err` = 0, `tt` = ~`EXP_TT`.
4. `DUT_LAT` = 2 with a block registered twice -> `match` = 1, `busy` for 130 cycles, `done` in cycle 130; a `start` pulse at cycle 60 is ignored.
5. Correct block except minterm 99 forced inverted -> `err_cnt` = 1, `first_err` = 99, `tt` = `EXP_TT` ^ (1 << 99).
6. `rst` asserted while `x` = 50 -> all outputs 0 at once, state IDLE; a `start` after release gives a clean sweep with `match` = 1.
